// File: rtl/sevenseg_scan_ctrl_if.sv
// rtl/sevenseg_scan_ctrl_if.sv - host/display signal bundle for the seven-segment scan controller
interface sevenseg_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    en;
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    blank_lz;
    logic                    update;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output en, value, dp_in, blank_lz, update,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  en, value, dp_in, blank_lz, update,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/sevenseg_scan_ctrl.sv
// rtl/sevenseg_scan_ctrl.sv - multiplexed common-anode seven-segment scanner with double-buffered data
module sevenseg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 131072,
    parameter int BLANK_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    sevenseg_scan_ctrl_if.slave     bus
);
    localparam int CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    generate
        if (BLANK_CYCLES >= SLOT_CYCLES || SLOT_CYCLES < 2 || NUM_DIGITS < 1) begin : g_bad_params
            $error("sevenseg_scan_ctrl: need BLANK_CYCLES<SLOT_CYCLES, SLOT_CYCLES>=2, NUM_DIGITS>=1");
        end
    endgenerate

    typedef enum logic {ST_BLANK, ST_ON} state_t;

    logic [CNT_W-1:0]      cnt_q, cnt_n;
    logic [IDX_W-1:0]      idx_q, idx_n;
    state_t                state;
    logic                  frame_start;

    logic [VAL_W-1:0]      pd_val_q, sh_val_q, sh_val_n;
    logic [NUM_DIGITS-1:0] pd_dp_q, sh_dp_q, sh_dp_n;
    logic                  pd_lz_q, sh_lz_q, sh_lz_n;
    logic                  pending_q;

    logic [NUM_DIGITS-1:0] lz_dark;
    logic [NUM_DIGITS-1:0] an_n;
    logic [6:0]            seg_n;
    logic                  dp_n;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        case (h)
            4'h0: hex_to_seg = 7'h40;  4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;  4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;  4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;  4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;  4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;  4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;  4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;  default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    // state register: slot counter and digit index
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_n;
            idx_q <= idx_n;
        end
    end

    // next-state logic; the slot phase is a pure function of cnt
    always_comb begin
        frame_start = bus.en && (cnt_q == '0) && (idx_q == '0);
        state       = (!bus.en || cnt_q < CNT_BLANK) ? ST_BLANK : ST_ON;
        cnt_n       = '0;
        idx_n       = '0;
        if (bus.en) begin
            cnt_n = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            idx_n = idx_q;
            if (cnt_q == CNT_LAST)
                idx_n = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    // shadow contents in effect from this cycle's edge onwards
    always_comb begin
        sh_val_n = sh_val_q;
        sh_dp_n  = sh_dp_q;
        sh_lz_n  = sh_lz_q;
        if (frame_start) begin
            if (bus.update) begin
                sh_val_n = bus.value;
                sh_dp_n  = bus.dp_in;
                sh_lz_n  = bus.blank_lz;
            end else if (pending_q) begin
                sh_val_n = pd_val_q;
                sh_dp_n  = pd_dp_q;
                sh_lz_n  = pd_lz_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pd_val_q  <= '0;
            pd_dp_q   <= '0;
            pd_lz_q   <= 1'b0;
            pending_q <= 1'b0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            sh_lz_q   <= 1'b0;
        end else begin
            sh_val_q <= sh_val_n;
            sh_dp_q  <= sh_dp_n;
            sh_lz_q  <= sh_lz_n;
            if (frame_start) begin
                pending_q <= 1'b0;
            end else if (bus.update) begin
                pd_val_q  <= bus.value;
                pd_dp_q   <= bus.dp_in;
                pd_lz_q   <= bus.blank_lz;
                pending_q <= 1'b1;
            end
        end
    end

    // a digit is dark when it and every digit above it are zero; digit 0 never is
    always_comb begin
        logic all_zero;
        all_zero = 1'b1;
        lz_dark  = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero && (sh_val_n[4*i +: 4] == 4'h0);
            lz_dark[i] = sh_lz_n && all_zero && (i != 0);
        end
    end

    // output logic
    always_comb begin
        an_n  = '1;
        seg_n = 7'h7F;
        dp_n  = 1'b1;
        if (state == ST_ON) begin
            an_n[idx_q] = 1'b0;
            seg_n       = lz_dark[idx_q] ? 7'h7F : hex_to_seg(sh_val_n[{idx_q, 2'b00} +: 4]);
            dp_n        = ~sh_dp_n[idx_q];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.an         <= '1;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= an_n;
            bus.seg        <= seg_n;
            bus.dp         <= dp_n;
            bus.frame_done <= frame_start;
        end
    end
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb/tb_sevenseg_scan_ctrl.sv - randomized and directed bench for sevenseg_scan_ctrl against a frame-position model
module tb_sevenseg_scan_ctrl;
    localparam int ND    = 4;
    localparam int SLOT  = 8;
    localparam int BLANK = 2;
    localparam int FRAME = ND * SLOT;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sevenseg_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    sevenseg_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SLOT_CYCLES (SLOT),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] hex7 [16];

    // model state: position within the frame, shadow and pending copies
    int          pos;
    logic [15:0] sh_val, pd_val;
    logic [3:0]  sh_dp, pd_dp;
    logic        sh_lz, pd_lz, pend;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        pos = 0;
        sh_val = '0; sh_dp = '0; sh_lz = 1'b0;
        pd_val = '0; pd_dp = '0; pd_lz = 1'b0; pend = 1'b0;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    endtask

    // what the next clock edge must produce, given the inputs now applied
    task automatic model_edge();
        int slot, off;
        logic [15:0] above;
        logic        fs;
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
        if (!bus.en) begin
            if (bus.update) begin
                pd_val = bus.value; pd_dp = bus.dp_in; pd_lz = bus.blank_lz; pend = 1'b1;
            end
            pos = 0;
        end else begin
            fs = (pos == 0);
            if (fs) begin
                if (bus.update) begin
                    sh_val = bus.value; sh_dp = bus.dp_in; sh_lz = bus.blank_lz;
                end else if (pend) begin
                    sh_val = pd_val; sh_dp = pd_dp; sh_lz = pd_lz;
                end
                pend = 1'b0;
            end else if (bus.update) begin
                pd_val = bus.value; pd_dp = bus.dp_in; pd_lz = bus.blank_lz; pend = 1'b1;
            end
            slot = pos / SLOT;
            off  = pos % SLOT;
            if (off >= BLANK) begin
                e_an  = ~(4'b0001 << slot);
                above = sh_val >> (4 * slot);
                e_seg = (sh_lz && slot > 0 && above == 16'h0) ? 7'h7F : hex7[above[3:0]];
                e_dp  = ~sh_dp[slot];
            end
            e_fd = fs;
            pos  = (pos + 1) % FRAME;
        end
    endtask

    task automatic compare_outputs();
        check("an", 32'(bus.an), 32'(e_an));
        check("seg", 32'(bus.seg), 32'(e_seg));
        check("dp", 32'(bus.dp), 32'(e_dp));
        check("frame_done", 32'(bus.frame_done), 32'(e_fd));
    endtask

    task automatic step();
        model_edge();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse_update(input logic [15:0] v, input logic [3:0] d, input logic lz);
        bus.value = v; bus.dp_in = d; bus.blank_lz = lz; bus.update = 1'b1;
        step();
        bus.update = 1'b0;
    endtask

    task automatic wait_pos(input int p);
        int guard;
        guard = 0;
        while (pos != p && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        check("wait_pos", 32'(pos), 32'(p));
    endtask

    initial begin
        hex7[0]  = 7'h40; hex7[1]  = 7'h79; hex7[2]  = 7'h24; hex7[3]  = 7'h30;
        hex7[4]  = 7'h19; hex7[5]  = 7'h12; hex7[6]  = 7'h02; hex7[7]  = 7'h78;
        hex7[8]  = 7'h00; hex7[9]  = 7'h10; hex7[10] = 7'h08; hex7[11] = 7'h03;
        hex7[12] = 7'h46; hex7[13] = 7'h21; hex7[14] = 7'h06; hex7[15] = 7'h0E;

        bus.en = 1'b1; bus.value = '0; bus.dp_in = '0; bus.blank_lz = 1'b0; bus.update = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_outputs();
        reset = 1'b0;

        // free-running scan of the all-zero shadow
        run(70);
        // hex decode and decimal point
        pulse_update(16'h12AF, 4'b0100, 1'b0);
        run(70);
        // leading-zero suppression
        pulse_update(16'h0050, 4'b0000, 1'b1);
        run(70);
        // two updates in one frame: last wins, applied next frame
        wait_pos(10);
        pulse_update(16'hBEEF, 4'b0001, 1'b0);
        run(5);
        pulse_update(16'h3C07, 4'b1000, 1'b1);
        run(70);
        // update on the frame-start cycle takes effect in that frame
        wait_pos(0);
        pulse_update(16'h0A09, 4'b0010, 1'b1);
        run(40);
        // en low mid-slot
        wait_pos(12);
        bus.en = 1'b0;
        run(5);
        bus.en = 1'b1;
        run(40);
        // asynchronous reset while digit 2 is lit
        wait_pos(21);
        #2 reset = 1'b1;
        #1;
        check("rst_an", 32'(bus.an), 32'hF);
        check("rst_seg", 32'(bus.seg), 32'h7F);
        check("rst_dp", 32'(bus.dp), 32'h1);
        check("rst_fd", 32'(bus.frame_done), 32'h0);
        model_reset();
        @(negedge clk);
        compare_outputs();
        reset = 1'b0;
        run(40);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bus.en       = ($urandom_range(0, 24) != 0);
            bus.update   = ($urandom_range(0, 11) == 0);
            bus.value    = 16'($urandom);
            bus.dp_in    = 4'($urandom);
            bus.blank_lz = 1'($urandom);
            if ($urandom_range(0, 3) == 0) bus.value = bus.value & 16'h00FF;
            step();
        end
        bus.update = 1'b0;
        bus.en = 1'b1;
        run(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
